// File: rtl/sequential_restoring_divider.sv
// Multi-cycle unsigned restoring divider for the execute stage.
// A start pulse in IDLE latches the operands. Each RUN cycle performs one
// trial subtraction, so a result takes n cycles. A zero divisor goes through
// a single ZERO cycle instead and returns the RISC-V DIVU/REMU results.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results from the last operation are held
// RUN   | one trial subtraction per cycle, n cycles in total
// ZERO  | one cycle for divide-by-zero, then report all-ones / dividend
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   start               request, sampled only in IDLE
//   dividend, divisor   operands (n bits), sampled with start
//   busy                high while an operation is in progress
//   done                one-cycle pulse when results become valid
//   quotient, remainder results (n bits), held until the next completion
//   div_by_zero         set with done when divisor was zero
module sequential_restoring_divider #(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);

    localparam int cw = $clog2(n + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [cw-1:0] cnt;
    logic [n-1:0]  r_q;     // partial remainder
    logic [n-1:0]  q_q;     // dividend bits shifting out, quotient bits shifting in
    logic [n-1:0]  d_q;     // latched divisor
    logic [n:0]    r_sh;
    logic [n:0]    t;
    logic          borrow;
    logic          last;
    logic [n-1:0]  r_nxt;
    logic [n-1:0]  q_nxt;

    // Because r_q < divisor always holds, r_sh < 2*divisor. A non-negative
    // difference is therefore below 2^n, and a negative one wraps to at
    // least 2^n. That makes bit n of the (n+1)-bit subtract the borrow.
    always_comb begin
        r_sh   = {r_q, q_q[n-1]};
        t      = r_sh - {1'b0, d_q};
        borrow = t[n];
        r_nxt  = borrow ? r_sh[n-1:0] : t[n-1:0];
        q_nxt  = {q_q[n-2:0], ~borrow};
        last   = (cnt == cw'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            ZERO: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q_q         <= dividend;
                        d_q         <= divisor;
                        r_q         <= '0;
                        cnt         <= cw'(n);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    cnt <= cnt - cw'(1);
                    if (last) begin
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
                        done      <= 1'b1;
                    end
                end
                ZERO: begin
                    // q_q still holds the untouched dividend here.
                    quotient    <= '1;
                    remainder   <= q_q;
                    div_by_zero <= 1'b1;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
